muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Sequencing controller for the HI/LO special registers that feed the register-file write-back path (`lo`/`hi` inputs, selected by `LHToReg`). It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands from the decode stage and runs a multi-cycle multiply countdown or a 32-step restoring divider. It owns HI/LO and raises a stall when a new command or an MFHI/MFLO read collides with an operation in flight.

## Interface
- `DATA_BITS`, 32, operand / HI / LO width.
- `MUL_CYCLES`, 3, multiply latency in cycles (must be ≥1).
- `clk  in  1  rising-edge clock`
- `rst_n  in  1  asynchronous, active-low reset`
- `start  in  1  command valid`
- `op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op`
- `rs_val  in  DATA_BITS  operand A / dividend / MTHI-MTLO source`
- `rt_val  in  DATA_BITS  operand B / divisor`
- `flush  in  1  cancel in-flight op (exception/branch squash)`
- `rd_hilo  in  1  decode stage is issuing MFHI/MFLO this cycle`
- `ready  out  1  idle, command accepted if start=1`
- `busy  out  1  MUL or DIV in progress`
- `stall  out  1  busy & (start | rd_hilo), combinational`
- `done  out  1  one-cycle pulse, HI/LO just updated by MUL/DIV`
- `div_zero  out  1  pulse with done when divisor was 0`
- `hi  out  DATA_BITS  HI register`
- `lo  out  DATA_BITS  LO register`

## Operation
- States: IDLE, MUL, DIV. `ready = (state==IDLE)`, `busy = !ready`.
- IDLE, start=1, accepted at edge k:
  - MTHI/MTLO: write `hi`/`lo` = rs_val at edge k; stay IDLE; no done pulse.
  - op 6-7: no effect, stay IDLE.
  - MULT/MULTU: latch operands, counter = MUL_CYCLES-1, go MUL.
  - DIV/DIVU: latch |dividend|, |divisor|, result signs; counter = DATA_BITS-1; go DIV.
- MUL: counter decrements; at counter==0 the product (2·DATA_BITS, signed for MULT, unsigned for MULTU) is written as {hi,lo}; done=1; go IDLE.
- DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit). After the last step: lo = quotient, hi = remainder; signed: quotient negated if signs differ, remainder takes dividend's sign; done=1; go IDLE.
- Divisor 0: run full length; result lo = all ones, hi = rs_val unmodified; div_zero=1 with done.
- Signed overflow (0x80000000 / -1): lo = 0x80000000, hi = 0.
- start while busy: ignored (ready=0), stall=1; upstream must hold start/op/operands.
- flush in MUL/DIV: return to IDLE at that edge, hi/lo unchanged, no done. flush in IDLE: no effect; flush with start same edge: flush wins, command dropped.

## Timing
- Reset (async, any state): state IDLE, hi=0, lo=0, done=0, div_zero=0, counter=0; ready=1, busy=0.
- Accept at edge k; MUL result at edge k+MUL_CYCLES; DIV result at edge k+DATA_BITS (+1 for sign fix-up, i.e. edge k+33 at 32 bits).
- done/div_zero asserted for exactly the cycle after the result edge; ready high in the same cycle, so a back-to-back command is accepted at the next edge.
- MTHI/MTLO: visible on hi/lo the cycle after acceptance.
- stall is purely combinational from busy, start, rd_hilo.

## Configuration
- `MULDIV_DIV_EN` defined: divider datapath and DIV state built as above.
- Undefined: no divider logic; DIV/DIVU accepted in IDLE, hi/lo unchanged, done and div_zero both pulse the following cycle, state never leaves IDLE.

## Test plan
- MULT rs=0xFFFFFFFD, rt=5 → done at k+3; hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULTU same operands → hi=0x00000004, lo=0xFFFFFFF1.
- DIVU 100/7 → done at k+33; lo=0x0000000E, hi=0x00000002; DIV 0xFFFFFFF9/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV rs=0x12345678, rt=0 → lo=0xFFFFFFFF, hi=0x12345678, div_zero=1 with done.
- DIV in flight, start=MTLO and rd_hilo=1 at cycle 5 → stall=1, lo untouched until done; MTLO accepted the cycle ready returns.
- flush at cycle 10 of DIV with prior hi=0xA, lo=0xB → IDLE next cycle, no done, hi/lo stay 0xA/0xB.
- rst_n low mid-MUL → immediately hi=lo=0, ready=1, busy=0, no done after release.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: HI/LO owner; sequences multi-cycle MUL/DIV and MTHI/MTLO writes.
// Latency: MUL result at accept+MUL_CYCLES, DIV at accept+DATA_BITS+1, MTHI/MTLO next cycle.
// Backpressure: start is ignored while busy; stall asks upstream to hold start/op/operands.
//
// Ports: clk/rst_n (async active-low); start/op/rs_val/rt_val command in;
//   flush cancels an in-flight MUL/DIV; rd_hilo flags an MFHI/MFLO read in decode;
//   ready/busy/stall status; done/div_zero one-cycle pulses; hi/lo register outputs.
// Option: define MULDIV_DIV_EN to build the restoring divider and the DIV state.
module muldiv_sequencer #(
  parameter int DATA_BITS  = 32,
  parameter int MUL_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [DATA_BITS-1:0] rs_val,
  input  logic [DATA_BITS-1:0] rt_val,
  input  logic                 flush,
  input  logic                 rd_hilo,
  output logic                 ready,
  output logic                 busy,
  output logic                 stall,
  output logic                 done,
  output logic                 div_zero,
  output logic [DATA_BITS-1:0] hi,
  output logic [DATA_BITS-1:0] lo
);
  localparam int N       = DATA_BITS;
  localparam int CNT_MAX = (N > MUL_CYCLES) ? N : MUL_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic [N-1:0]     a_q, a_d, b_q, b_d;
  logic             sgn_q, sgn_d;
  logic             done_q, done_d, dz_q, dz_d;

  // Full-width product of the latched operands, sign- or zero-extended.
  logic [2*N-1:0]   ext_a, ext_b, prod;
  assign ext_a = sgn_q ? {{N{a_q[N-1]}}, a_q} : {{N{1'b0}}, a_q};
  assign ext_b = sgn_q ? {{N{b_q[N-1]}}, b_q} : {{N{1'b0}}, b_q};
  assign prod  = ext_a * ext_b;

`ifdef MULDIV_DIV_EN
  // a_q is the dividend/quotient shift register, b_q the divisor magnitude.
  logic [N-1:0] rem_q, rem_d;
  logic         neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, zdiv_q, zdiv_d;
  logic         fix_q, fix_d;
  logic         div_signed, rs_neg, rt_neg;
  logic [N:0]   shifted;
  logic [N-1:0] trial;
  logic         ge;

  assign div_signed = (op == OP_DIV);
  assign rs_neg     = div_signed & rs_val[N-1];
  assign rt_neg     = div_signed & rt_val[N-1];
  assign shifted    = {rem_q, a_q[N-1]};
  assign ge         = (shifted >= {1'b0, b_q});
  // With a zero divisor the trial always succeeds; truncation then leaves the
  // remainder equal to the dividend magnitude after the final step.
  assign trial      = shifted[N-1:0] - b_q;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
`ifdef MULDIV_DIV_EN
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zdiv_q    <= 1'b0;
      fix_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sgn_q     <= sgn_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
`ifdef MULDIV_DIV_EN
      rem_q     <= rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      zdiv_q    <= zdiv_d;
      fix_q     <= fix_d;
`endif
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
`ifdef MULDIV_DIV_EN
    rem_d     = rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    zdiv_d    = zdiv_q;
    fix_d     = fix_q;
`endif
    case (state_q)
      S_IDLE: begin
        // A squash in the same cycle drops the command entirely.
        if (start && !flush) begin
          case (op)
            OP_MTHI: hi_d = rs_val;
            OP_MTLO: lo_d = rs_val;
            OP_MULT, OP_MULTU: begin
              a_d     = rs_val;
              b_d     = rt_val;
              sgn_d   = (op == OP_MULT);
              cnt_d   = CNT_W'(MUL_CYCLES - 1);
              state_d = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
`ifdef MULDIV_DIV_EN
              a_d       = rs_neg ? -rs_val : rs_val;
              b_d       = rt_neg ? -rt_val : rt_val;
              rem_d     = '0;
              neg_quo_d = rs_neg ^ rt_neg;
              neg_rem_d = rs_neg;
              zdiv_d    = (rt_val == '0);
              fix_d     = 1'b0;
              cnt_d     = CNT_W'(N - 1);
              state_d   = S_DIV;
`else
              done_d = 1'b1;
              dz_d   = 1'b1;
`endif
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          hi_d    = prod[2*N-1:N];
          lo_d    = prod[N-1:0];
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DIV: begin
`ifdef MULDIV_DIV_EN
        if (flush) begin
          state_d = S_IDLE;
        end else if (fix_q) begin
          // Sign fix-up cycle; a zero divisor keeps the all-ones quotient.
          lo_d    = (neg_quo_q && !zdiv_q) ? -a_q : a_q;
          hi_d    = neg_rem_q ? -rem_q : rem_q;
          done_d  = 1'b1;
          dz_d    = zdiv_q;
          fix_d   = 1'b0;
          state_d = S_IDLE;
        end else begin
          rem_d = ge ? trial : shifted[N-1:0];
          a_d   = {a_q[N-2:0], ge};
          if (cnt_q == '0) fix_d = 1'b1;
          else             cnt_d = cnt_q - 1'b1;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    ready    = (state_q == S_IDLE);
    busy     = (state_q != S_IDLE);
    stall    = (state_q != S_IDLE) & (start | rd_hilo);
    done     = done_q;
    div_zero = dz_q;
    hi       = hi_q;
    lo       = lo_q;
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed bench for muldiv_sequencer with a result scoreboard.
// Commands push their expected HI/LO/div_zero; the entry is popped when done pulses.
// Divider checks follow MULDIV_DIV_EN the same way the design does.
module tb_muldiv_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, flush, rd_hilo;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        ready, busy, stall, done, div_zero;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_hi, m_lo;

  localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3;
  localparam logic [2:0] MTHI = 3'd4, MTLO = 3'd5, NOP = 3'd6;

  muldiv_sequencer #(.DATA_BITS(32), .MUL_CYCLES(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .flush    (flush),
    .rd_hilo  (rd_hilo),
    .ready    (ready),
    .busy     (busy),
    .stall    (stall),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mul_model(input logic s, input logic [31:0] a, input logic [31:0] b);
    exp_t        r;
    logic [63:0] p;
    if (s) p = 64'(longint'($signed(a)) * longint'($signed(b)));
    else   p = {32'd0, a} * {32'd0, b};
    r.hi = p[63:32];
    r.lo = p[31:0];
    r.dz = 1'b0;
    return r;
  endfunction

  // Issue one MUL/DIV, wait for done and compare against the scoreboard head.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input exp_t e, input int lat, input string tag);
    int   n;
    exp_t x;
    sb.push_back(e);
    chk({tag, "_ready"}, ready, 1);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    tick();
    start = 1'b0;
    if (lat > 0) chk({tag, "_busy"}, busy, 1);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_latency"}, 64'(n), 64'(lat));
    x = sb.pop_front();
    chk({tag, "_hi"}, hi, x.hi);
    chk({tag, "_lo"}, lo, x.lo);
    chk({tag, "_div_zero"}, div_zero, x.dz);
    chk({tag, "_ready_at_done"}, ready, 1);
    m_hi = x.hi;
    m_lo = x.lo;
  endtask

  task automatic write_hilo(input logic [2:0] o, input logic [31:0] v, input string tag);
    start = 1'b1; op = o; rs_val = v;
    tick();
    start = 1'b0;
    if (o == MTHI) m_hi = v;
    else           m_lo = v;
    chk({tag, "_hi"}, hi, m_hi);
    chk({tag, "_lo"}, lo, m_lo);
    chk({tag, "_no_done"}, done, 0);
  endtask

  // Start an op, then after wc cycles present MTLO plus an MFxx read and hold them.
  task automatic stall_test(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            input exp_t e, input int lat, input int wc, input string tag);
    int          n;
    logic        bad;
    logic [31:0] old_lo;
    exp_t        x;
    old_lo = m_lo;
    sb.push_back(e);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    tick();
    start = 1'b0;
    n = 0;
    repeat (wc) begin
      tick();
      n++;
    end
    start = 1'b1; op = MTLO; rs_val = 32'h0000_0055; rt_val = 32'd0; rd_hilo = 1'b1;
    #1;
    chk({tag, "_stall"}, stall, 1);
    chk({tag, "_not_ready"}, ready, 0);
    bad = 1'b0;
    while (done !== 1'b1 && n < 100) begin
      if (stall !== 1'b1 || lo !== old_lo) bad = 1'b1;
      tick();
      n++;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_latency"}, 64'(n), 64'(lat));
    chk({tag, "_held_stall_lo"}, bad, 0);
    x = sb.pop_front();
    chk({tag, "_hi"}, hi, x.hi);
    chk({tag, "_lo"}, lo, x.lo);
    chk({tag, "_stall_released"}, stall, 0);
    chk({tag, "_ready_again"}, ready, 1);
    tick();
    start = 1'b0; rd_hilo = 1'b0;
    chk({tag, "_mtlo_lo"}, lo, 32'h0000_0055);
    chk({tag, "_mtlo_hi"}, hi, x.hi);
    chk({tag, "_mtlo_no_done"}, done, 0);
    m_hi = x.hi;
    m_lo = 32'h0000_0055;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [31:0] ra, rb;
    logic        seen;

    start = 1'b0; flush = 1'b0; rd_hilo = 1'b0; op = 3'd0;
    rs_val = '0; rt_val = '0; rst_n = 1'b1;
    m_hi = '0; m_lo = '0;
    #2 rst_n = 1'b0;
    #2;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_done", done, 0);
    chk("rst_div_zero", div_zero, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Multiply: signed and unsigned, back-to-back.
    run_op(MULT,  32'hFFFF_FFFD, 32'd5, '{32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0}, 3, "mult");
    run_op(MULTU, 32'hFFFF_FFFD, 32'd5, '{32'h0000_0004, 32'hFFFF_FFF1, 1'b0}, 3, "multu");
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_op((i % 2 == 0) ? MULT : MULTU, ra, rb, mul_model(i % 2 == 0, ra, rb), 3, "mul_rand");
    end

    // MTHI/MTLO and a no-op command.
    write_hilo(MTHI, 32'h1111_2222, "mthi");
    write_hilo(MTLO, 32'h3333_4444, "mtlo");
    start = 1'b1; op = NOP; rs_val = 32'h9999_9999;
    tick();
    start = 1'b0;
    chk("nop_hi", hi, m_hi);
    chk("nop_lo", lo, m_lo);
    chk("nop_ready", ready, 1);
    chk("nop_done", done, 0);

`ifdef MULDIV_DIV_EN
    run_op(DIVU, 32'd100,        32'd7,        '{32'h0000_0002, 32'h0000_000E, 1'b0}, 33, "divu");
    run_op(DIV,  32'hFFFF_FFF9,  32'd2,        '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0}, 33, "div_neg");
    run_op(DIV,  32'h1234_5678,  32'd0,        '{32'h1234_5678, 32'hFFFF_FFFF, 1'b1}, 33, "div_zero");
    run_op(DIV,  32'hFFFF_FFF9,  32'd0,        '{32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1}, 33, "div_zero_neg");
    run_op(DIV,  32'h8000_0000,  32'hFFFF_FFFF,'{32'h0000_0000, 32'h8000_0000, 1'b0}, 33, "div_ovf");
    stall_test(DIVU, 32'd1000, 32'd3, '{32'h0000_0001, 32'h0000_014D, 1'b0}, 33, 5, "stall_div");
`else
    // Without the divider, DIV/DIVU leave HI/LO alone and pulse done with div_zero.
    run_op(DIVU, 32'd100, 32'd7, '{m_hi, m_lo, 1'b1}, 0, "divu_off");
    run_op(DIV,  32'h1234_5678, 32'd0, '{m_hi, m_lo, 1'b1}, 0, "div_off");
`endif
    stall_test(MULT, 32'd6, 32'hFFFF_FFFE, '{32'hFFFF_FFFF, 32'hFFFF_FFF4, 1'b0}, 3, 1, "stall_mul");

    // Flush mid-operation leaves HI/LO untouched and produces no done.
    write_hilo(MTHI, 32'h0000_000A, "pre_flush_hi");
    write_hilo(MTLO, 32'h0000_000B, "pre_flush_lo");
`ifdef MULDIV_DIV_EN
    start = 1'b1; op = DIVU; rs_val = 32'd500; rt_val = 32'd9;
    tick();
    start = 1'b0;
    repeat (9) tick();
`else
    start = 1'b1; op = MULTU; rs_val = 32'd500; rt_val = 32'd9;
    tick();
    start = 1'b0;
`endif
    chk("flush_busy_before", busy, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_ready", ready, 1);
    chk("flush_busy", busy, 0);
    seen = 1'b0;
    repeat (40) begin
      if (done !== 1'b0) seen = 1'b1;
      tick();
    end
    chk("flush_no_done", seen, 0);
    chk("flush_hi", hi, 32'h0000_000A);
    chk("flush_lo", lo, 32'h0000_000B);

    // Flush with start in IDLE drops the command.
    start = 1'b1; op = MTHI; rs_val = 32'h0000_0077; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flush_idle_hi", hi, 32'h0000_000A);
    chk("flush_idle_ready", ready, 1);

    // Asynchronous reset in the middle of a multiply.
    start = 1'b1; op = MULT; rs_val = 32'd3; rt_val = 32'd4;
    tick();
    start = 1'b0;
    tick();
    chk("rst_mid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_hi", hi, 0);
    chk("rst_mid_lo", lo, 0);
    chk("rst_mid_ready", ready, 1);
    chk("rst_mid_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      if (done !== 1'b0) seen = 1'b1;
      tick();
    end
    chk("rst_mid_no_done", seen, 0);
    chk("rst_mid_hi_after", hi, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
